// File: rtl/sequential_alu.sv
// Multi-cycle ALU: single-cycle logic/arith ops, shift-add MUL, restoring DIV.
// Divider present only when ALU_DIVIDE_EN is defined; otherwise FunSel=15 is a 1-cycle stub.
module sequential_alu #(
    parameter int WIDTH = 32
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       FunSel,
    input  logic             Start,
    input  logic             WF,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] ALUOut,
    output logic [WIDTH-1:0] ALUOutHi,
    output logic [3:0]       FlagsOut
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_e;

    state_e           state_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] hi_q;
    logic [3:0]       flags_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] mq_q;
    logic [CW-1:0]    cnt_q;
    logic             wf_q;

    assign Busy     = busy_q;
    assign Done     = done_q;
    assign ALUOut   = out_q;
    assign ALUOutHi = hi_q;
    assign FlagsOut = flags_q;

    function automatic logic [3:0] mk_flags(
        input logic [WIDTH-1:0] r,
        input logic             c,
        input logic             o
    );
        return {r == '0, c, r[WIDTH-1], o};
    endfunction

    logic             cin;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] sc_res;
    logic             sc_c;
    logic             sc_o;

    assign cin = flags_q[2];

    always_comb begin
        sum    = '0;
        sc_res = '0;
        sc_c   = 1'b0;
        sc_o   = 1'b0;
        unique case (FunSel)
            4'd0: sc_res = A;
            4'd1: sc_res = B;
            4'd2: sc_res = ~A;
            4'd3, 4'd4: begin
                sum = {1'b0, A} + {1'b0, B}
                    + {{WIDTH{1'b0}}, (FunSel == 4'd4) & cin};
                sc_res = sum[WIDTH-1:0];
                sc_c   = sum[WIDTH];
                sc_o   = (A[WIDTH-1] == B[WIDTH-1])
                       & (sc_res[WIDTH-1] != A[WIDTH-1]);
            end
            4'd5: begin
                sum    = {1'b0, A} - {1'b0, B};
                sc_res = sum[WIDTH-1:0];
                sc_c   = ~sum[WIDTH];
                sc_o   = (A[WIDTH-1] != B[WIDTH-1])
                       & (sc_res[WIDTH-1] != A[WIDTH-1]);
            end
            4'd6: sc_res = A & B;
            4'd7: sc_res = A | B;
            4'd8: sc_res = A ^ B;
            4'd9: sc_res = ~(A & B);
            4'd10: begin
                sc_res = {A[WIDTH-2:0], 1'b0};
                sc_c   = A[WIDTH-1];
            end
            4'd11: begin
                sc_res = {1'b0, A[WIDTH-1:1]};
                sc_c   = A[0];
            end
            4'd12: begin
                sc_res = {A[WIDTH-1], A[WIDTH-1:1]};
                sc_c   = A[0];
            end
            4'd13: begin
                sc_res = {cin, A[WIDTH-1:1]};
                sc_c   = A[0];
            end
            default: sc_o = (FunSel == 4'd15);
        endcase
    end

    // One shift-add step: product high half in acc_q, multiplier/low half in mq_q
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi;
    logic [WIDTH-1:0] mul_lo;

    assign mul_sum = {1'b0, acc_q} + ({1'b0, a_q} & {(WIDTH+1){mq_q[0]}});
    assign mul_hi  = mul_sum[WIDTH:1];
    assign mul_lo  = {mul_sum[0], mq_q[WIDTH-1:1]};

`ifdef ALU_DIVIDE_EN
    // Restoring step: remainder in acc_q, dividend/quotient in mq_q
    logic [WIDTH-1:0] b_q;
    logic [WIDTH:0]   div_sh;
    logic [WIDTH:0]   div_tr;
    logic             div_ok;
    logic [WIDTH-1:0] div_rem;
    logic [WIDTH-1:0] div_quo;

    assign div_sh  = {acc_q, mq_q[WIDTH-1]};
    assign div_tr  = div_sh - {1'b0, b_q};
    assign div_ok  = ~div_tr[WIDTH];
    assign div_rem = div_ok ? div_tr[WIDTH-1:0] : div_sh[WIDTH-1:0];
    assign div_quo = {mq_q[WIDTH-2:0], div_ok};
`endif

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            out_q   <= '0;
            hi_q    <= '0;
            flags_q <= '0;
            a_q     <= '0;
            acc_q   <= '0;
            mq_q    <= '0;
            cnt_q   <= '0;
            wf_q    <= 1'b0;
`ifdef ALU_DIVIDE_EN
            b_q     <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: if (Start) begin
                    a_q   <= A;
                    wf_q  <= WF;
                    cnt_q <= '0;
                    busy_q <= 1'b1;
`ifdef ALU_DIVIDE_EN
                    b_q   <= B;
`endif
                    if (FunSel == 4'd14) begin
                        state_q <= MUL;
                        acc_q   <= '0;
                        mq_q    <= B;
`ifdef ALU_DIVIDE_EN
                    end else if (FunSel == 4'd15 && B != '0) begin
                        state_q <= DIV;
                        acc_q   <= '0;
                        mq_q    <= A;
                    end else if (FunSel == 4'd15) begin
                        state_q <= FIN;
                        done_q  <= 1'b1;
                        out_q   <= '1;
                        hi_q    <= A;
                        if (WF) flags_q <= mk_flags('1, 1'b0, 1'b1);
`endif
                    end else begin
                        state_q <= FIN;
                        done_q  <= 1'b1;
                        out_q   <= sc_res;
                        hi_q    <= '0;
                        if (WF) flags_q <= mk_flags(sc_res, sc_c, sc_o);
                    end
                end
                MUL: begin
                    acc_q <= mul_hi;
                    mq_q  <= mul_lo;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_q <= FIN;
                        done_q  <= 1'b1;
                        out_q   <= mul_lo;
                        hi_q    <= mul_hi;
                        if (wf_q)
                            flags_q <= mk_flags(mul_lo, mul_hi != '0, 1'b0);
                    end
                end
`ifdef ALU_DIVIDE_EN
                DIV: begin
                    acc_q <= div_rem;
                    mq_q  <= div_quo;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_q <= FIN;
                        done_q  <= 1'b1;
                        out_q   <= div_quo;
                        hi_q    <= div_rem;
                        if (wf_q)
                            flags_q <= mk_flags(div_quo, 1'b0, 1'b0);
                    end
                end
`endif
                FIN: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule
